// File: rtl/bram_512_512_banked_if.sv
// Port bundle for bram_512_512_banked: full-width write port, 16 per-lane read
// addresses and the gathered 512-bit read word.
interface bram_512_512_banked_if #(
  parameter int WIDTH  = 512,
  parameter int ADDR_W = 9
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WIDTH-1:0]  dina;
  logic [ADDR_W-1:0] addrb_0,  addrb_1,  addrb_2,  addrb_3;
  logic [ADDR_W-1:0] addrb_4,  addrb_5,  addrb_6,  addrb_7;
  logic [ADDR_W-1:0] addrb_8,  addrb_9,  addrb_10, addrb_11;
  logic [ADDR_W-1:0] addrb_12, addrb_13, addrb_14, addrb_15;
  logic [WIDTH-1:0]  doutb;

  modport master (
    output wea, addra, dina,
    output addrb_0,  addrb_1,  addrb_2,  addrb_3,
    output addrb_4,  addrb_5,  addrb_6,  addrb_7,
    output addrb_8,  addrb_9,  addrb_10, addrb_11,
    output addrb_12, addrb_13, addrb_14, addrb_15,
    input  doutb
  );

  modport slave (
    input  wea, addra, dina,
    input  addrb_0,  addrb_1,  addrb_2,  addrb_3,
    input  addrb_4,  addrb_5,  addrb_6,  addrb_7,
    input  addrb_8,  addrb_9,  addrb_10, addrb_11,
    input  addrb_12, addrb_13, addrb_14, addrb_15,
    output doutb
  );
endinterface

// File: rtl/bram_512_512_banked.sv
// 512x512 simple dual-port RAM split into 16 lane banks with independent read rows.
// Define BRAM_DOUT_REG_EN to add a second output register (read latency 2).
module bram_512_512_banked #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 512,
  parameter int LANES  = 16,
  parameter int LANE_W = WIDTH / LANES,
  parameter int ADDR_W = 9
) (
  input logic                    clka,
  input logic                    rstb,
  bram_512_512_banked_if.slave   bus
);

  logic [ADDR_W-1:0] w_addrb [LANES];
  logic [LANE_W-1:0] w_rd_p0 [LANES];
  logic [WIDTH-1:0]  w_dout_p0;

  assign w_addrb[0]  = bus.addrb_0;
  assign w_addrb[1]  = bus.addrb_1;
  assign w_addrb[2]  = bus.addrb_2;
  assign w_addrb[3]  = bus.addrb_3;
  assign w_addrb[4]  = bus.addrb_4;
  assign w_addrb[5]  = bus.addrb_5;
  assign w_addrb[6]  = bus.addrb_6;
  assign w_addrb[7]  = bus.addrb_7;
  assign w_addrb[8]  = bus.addrb_8;
  assign w_addrb[9]  = bus.addrb_9;
  assign w_addrb[10] = bus.addrb_10;
  assign w_addrb[11] = bus.addrb_11;
  assign w_addrb[12] = bus.addrb_12;
  assign w_addrb[13] = bus.addrb_13;
  assign w_addrb[14] = bus.addrb_14;
  assign w_addrb[15] = bus.addrb_15;

  // Stage p0: one bank per lane; write and read share the edge, so a same-row
  // read returns the pre-write contents. Only the read register is reset.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [LANE_W-1:0] r_rd_p0;

    always_ff @(posedge clka) begin
      if (bus.wea) begin
        r_mem[bus.addra] <= bus.dina[g*LANE_W +: LANE_W];
      end
    end

    always_ff @(posedge clka or posedge rstb) begin
      if (rstb) begin
        r_rd_p0 <= '0;
      end else begin
        r_rd_p0 <= r_mem[w_addrb[g]];
      end
    end

    assign w_rd_p0[g] = r_rd_p0;
  end

  always_comb begin
    w_dout_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      w_dout_p0[i*LANE_W +: LANE_W] = w_rd_p0[i];
    end
  end

`ifdef BRAM_DOUT_REG_EN
  // Stage p1: optional output register, cleared together with p0.
  logic [WIDTH-1:0] r_dout_p1;

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      r_dout_p1 <= '0;
    end else begin
      r_dout_p1 <= w_dout_p0;
    end
  end

  assign bus.doutb = r_dout_p1;
`else
  assign bus.doutb = w_dout_p0;
`endif

endmodule

// File: tb/tb_bram_512_512_banked.sv
// Self-checking bench for bram_512_512_banked: array-based memory model with a
// per-edge compare process, plus directed literal checks.
module tb_bram_512_512_banked;
`ifdef BRAM_DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clka = 1'b0;
  logic rstb = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] tb_addrb [16];

  bram_512_512_banked_if bus ();

  bram_512_512_banked dut (
    .clka (clka),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  assign bus.addrb_0  = tb_addrb[0];
  assign bus.addrb_1  = tb_addrb[1];
  assign bus.addrb_2  = tb_addrb[2];
  assign bus.addrb_3  = tb_addrb[3];
  assign bus.addrb_4  = tb_addrb[4];
  assign bus.addrb_5  = tb_addrb[5];
  assign bus.addrb_6  = tb_addrb[6];
  assign bus.addrb_7  = tb_addrb[7];
  assign bus.addrb_8  = tb_addrb[8];
  assign bus.addrb_9  = tb_addrb[9];
  assign bus.addrb_10 = tb_addrb[10];
  assign bus.addrb_11 = tb_addrb[11];
  assign bus.addrb_12 = tb_addrb[12];
  assign bus.addrb_13 = tb_addrb[13];
  assign bus.addrb_14 = tb_addrb[14];
  assign bus.addrb_15 = tb_addrb[15];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: plain word array, rows become known once written.
  logic [511:0] mmem   [512];
  bit           mknown [512];
  logic [511:0] pv [2];
  bit           pk [2];

  initial begin
    pv[0] = '0; pv[1] = '0;
    pk[0] = 1'b0; pk[1] = 1'b0;
  end

  always @(posedge clka) begin
    logic [511:0] rd;
    bit           k;
    rd = '0;
    k  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd[32*i +: 32] = mmem[tb_addrb[i]][32*i +: 32];
      k = k & mknown[tb_addrb[i]];
    end
    if (bus.wea) begin
      mmem[bus.addra]   = bus.dina;
      mknown[bus.addra] = 1'b1;
    end
    if (LAT == 2) begin
      pv[1] = rstb ? '0 : pv[0];
      pk[1] = rstb ? 1'b1 : pk[0];
    end
    pv[0] = rstb ? '0 : rd;
    pk[0] = rstb ? 1'b1 : k;
    #1;
    if (pk[LAT-1]) check("stream", bus.doutb, pv[LAT-1]);
  end

  task automatic set_all(input logic [8:0] a);
    for (int i = 0; i < 16; i++) tb_addrb[i] = a;
  endtask

  task automatic write_row(input logic [8:0] a, input logic [511:0] d);
    @(negedge clka);
    bus.wea = 1'b1; bus.addra = a; bus.dina = d;
    @(negedge clka);
    bus.wea = 1'b0;
  endtask

  task automatic read_row(input logic [8:0] a);
    @(negedge clka);
    bus.wea = 1'b0;
    set_all(a);
    repeat (LAT) @(posedge clka);
    #1;
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp;
    logic [511:0] d;
    logic [8:0]   r;

    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    for (int i = 0; i < 16; i++) tb_addrb[i] = 9'($urandom);

    // Reset state, both immediately and held across edges.
    #1;
    check("reset_now", bus.doutb, '0);
    repeat (3) @(posedge clka);
    #1;
    check("reset_held", bus.doutb, '0);

    // Sequential fill while reset is still held: writes must land anyway.
    for (int a = 0; a < 512; a++) begin
      @(negedge clka);
      bus.wea = 1'b1; bus.addra = 9'(a); bus.dina = 512'(a);
    end
    @(negedge clka);
    bus.wea = 1'b0;
    set_all(9'd7);
    #1;
    check("reset_fill", bus.doutb, '0);

    // Release reset; data for address 7 appears after LAT edges.
    @(negedge clka);
    rstb = 1'b0;
    for (int e = 0; e < LAT - 1; e++) begin
      @(posedge clka); #1;
      check("release_early", bus.doutb, '0);
    end
    @(posedge clka); #1;
    check("release_first", bus.doutb, 512'd7);

    // Pulse reset, then sweep all lanes 0..511 together.
    @(negedge clka);
    rstb = 1'b1;
    #1;
    check("pulse_now", bus.doutb, '0);
    @(negedge clka);
    rstb = 1'b0;
    for (int a = 0; a < 512; a++) begin
      set_all(9'(a));
      @(negedge clka);
    end
    read_row(9'd0);   check("seq_0",   bus.doutb, 512'd0);
    read_row(9'd1);   check("seq_1",   bus.doutb, 512'd1);
    read_row(9'd300); check("seq_300", bus.doutb, 512'd300);
    read_row(9'd511); check("seq_511", bus.doutb, 512'd511);

    // Per-lane gather: every lane holds the row index, lane i reads row 10*i+3.
    for (int k = 0; k < 512; k++) begin
      @(negedge clka);
      bus.wea = 1'b1; bus.addra = 9'(k);
      for (int i = 0; i < 16; i++) bus.dina[32*i +: 32] = 32'(k);
    end
    @(negedge clka);
    bus.wea = 1'b0;
    for (int i = 0; i < 16; i++) tb_addrb[i] = 9'(10*i + 3);
    repeat (LAT) @(posedge clka);
    #1;
    exp = '0;
    for (int i = 0; i < 16; i++) exp[32*i +: 32] = 32'(10*i + 3);
    check("gather", bus.doutb, exp);

    // Read-during-write on row 5 returns the old word first.
    write_row(9'd5, {128{4'hA}});
    @(negedge clka);
    bus.wea = 1'b1; bus.addra = 9'd5; bus.dina = {128{4'h5}};
    set_all(9'd5);
    repeat (LAT) @(posedge clka);
    #1;
    check("rdw_old", bus.doutb, {128{4'hA}});
    @(posedge clka); #1;
    check("rdw_new", bus.doutb, {128{4'h5}});
    @(negedge clka);
    bus.wea = 1'b0;

    // Boundary rows with distinct patterns, including a per-lane mix.
    write_row(9'd0,   {16{32'hDEAD_0000}});
    write_row(9'd511, {16{32'h0000_BEEF}});
    read_row(9'd0);   check("bound_0",   bus.doutb, {16{32'hDEAD_0000}});
    read_row(9'd511); check("bound_511", bus.doutb, {16{32'h0000_BEEF}});
    @(negedge clka);
    for (int i = 0; i < 16; i++) tb_addrb[i] = (i % 2 == 0) ? 9'd0 : 9'd511;
    repeat (LAT) @(posedge clka);
    #1;
    check("bound_mix", bus.doutb, {8{32'h0000_BEEF, 32'hDEAD_0000}});

    // Randomized traffic, biased toward a few rows to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      @(negedge clka);
      bus.wea   = 1'($urandom_range(0, 1));
      bus.addra = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom);
      bus.dina  = rand_word();
      for (int i = 0; i < 16; i++)
        tb_addrb[i] = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom);
    end

    // Reset asserted mid-cycle while a write is pending; the write must land.
    r = 9'd77;
    d = rand_word();
    @(posedge clka);
    #2;
    rstb = 1'b1;
    #1;
    check("midrst_now", bus.doutb, '0);
    @(negedge clka);
    bus.wea = 1'b1; bus.addra = r; bus.dina = d;
    @(negedge clka);
    bus.wea = 1'b0;
    #1;
    check("midrst_held", bus.doutb, '0);
    @(negedge clka);
    rstb = 1'b0;
    read_row(r);
    check("midrst_write", bus.doutb, d);

    repeat (4) @(posedge clka);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
